instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have a clock port clk, an input of width 1; all state SHALL update on its rising edge.
REQ-002 The module SHALL have a reset port rst_n, an input of width 1, which is asynchronous and active-low.
REQ-003 The module SHALL have an input load_en of width 1, which writes one program word when high.
REQ-004 The module SHALL have an input load_addr of width 4, the program memory write address.
REQ-005 The module SHALL have an input load_data of width 16, the program word to write.
REQ-006 The module SHALL have an input prog_len of width 5, the number of instructions to issue, with valid values 1..16.
REQ-007 The module SHALL have an input start of width 1, a one-cycle request to begin issuing.
REQ-008 The module SHALL have an input stall of width 1, a downstream hold request.
REQ-009 The module SHALL have an input abort of width 1, which terminates a run.
REQ-010 The module SHALL have an output instruction of width 16, the registered instruction word for the execute stage.
REQ-011 The module SHALL have an output instr_valid of width 1, high when instruction must be executed this clock.
REQ-012 The module SHALL have an output pc of width 4, the index of the word currently presented.
REQ-013 The module SHALL have an output busy of width 1, high in the RUN state.
REQ-014 The module SHALL have an output done of width 1, high in the DONE state.

Function
REQ-015 The module SHALL hold a program memory of 16 words of 16 bits each, written only from load_en/load_addr/load_data.
REQ-016 The module SHALL implement a state machine with the states IDLE, RUN and DONE.
REQ-017 A load SHALL be accepted only in IDLE or DONE; a load in DONE SHALL return the machine to IDLE; a load in RUN SHALL be ignored.
REQ-018 When start is high in IDLE or DONE, load_en is low and prog_len is not 0, the machine SHALL go to RUN on the next edge with pc=0, instruction=mem[0] and instr_valid=1.
REQ-019 If start and load_en are high in the same cycle, the load SHALL take priority and start SHALL be ignored.
REQ-020 A start with prog_len=0 SHALL be ignored.
REQ-021 A prog_len greater than 16 SHALL be treated as 16.
REQ-022 In RUN with stall low, each edge SHALL advance pc by 1 and present mem[pc+1] with instr_valid=1, giving exactly one issued word per cycle.
REQ-023 In RUN with stall high, pc and instruction SHALL hold and instr_valid SHALL be 0 on the next edge; the word SHALL re-issue with instr_valid=1 on the first edge after stall falls.
REQ-024 In RUN, the edge after the word at pc=prog_len-1 has been issued unstalled SHALL enter DONE with instr_valid=0, with instruction and pc holding their last values.
REQ-025 A stall in the same cycle as the last word SHALL defer DONE until that word is issued.
REQ-026 In DONE, done SHALL stay 1 until the next accepted start or load.
REQ-027 An abort in RUN SHALL enter IDLE on the next edge with instr_valid=0 and pc=0.
REQ-028 Abort SHALL take priority over stall and end-of-program, and SHALL be ignored outside RUN.
REQ-029 The signals busy, done and instr_valid SHALL never be high together, except that busy and instr_valid are high together while issuing in RUN.

Reset
REQ-030 When rst_n is low, the module SHALL immediately set state=IDLE, instruction=16'h0000, instr_valid=0, pc=0, busy=0 and done=0.
REQ-031 Program memory contents SHALL be retained across reset.
REQ-032 A reset during RUN SHALL abandon the run and issue no further words.

Configuration
REQ-033 When the macro INSTR_FETCH_LOOP_EN is defined, reaching the end of the program SHALL wrap pc to 0 and continue issuing mem[0] in RUN without entering DONE; in that case only abort or reset ends the run.
REQ-034 When INSTR_FETCH_LOOP_EN is not defined, the end of the program SHALL enter DONE as specified in REQ-024.

Verification
REQ-035 Load mem[0..2]=16'h0051, 16'h0062, 16'hB012, then prog_len=3 and pulse start -> instr_valid high for exactly 3 consecutive cycles presenting 0051, 0062, B012 with pc 0, 1, 2, then done=1 and busy=0.
REQ-036 Same program with stall high for 2 cycles while pc=1 -> 0062 issued with instr_valid=1 exactly once, 5 valid-or-stalled cycles in total, and the issue order unchanged.
REQ-037 prog_len=0 plus start -> remains IDLE with instr_valid=0; prog_len=20 -> exactly 16 words issued, pc 0..15.
REQ-038 Abort asserted at pc=1 -> the next cycle has instr_valid=0, pc=0, busy=0 and done=0; a load attempted mid-run at address 0 leaves mem[0] unchanged.
REQ-039 rst_n pulsed low mid-run -> outputs go to their reset values without waiting for clk; a following start re-issues the retained program from pc=0.
REQ-040 With INSTR_FETCH_LOOP_EN defined and prog_len=2 -> the issue sequence is mem0, mem1, mem0, mem1, ... and done never goes high until abort.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: program memory plus issue sequencer feeding an execute stage.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   load_en/load_addr/load_data write one 16-bit word into the 16-entry program memory
//   prog_len                    number of words to issue (0 ignored, >16 treated as 16)
//   start, stall, abort         run request, downstream hold, run termination
//   instruction, instr_valid    registered word for execute and its issue strobe
//   pc, busy, done              index of the presented word, RUN state, DONE state
// Build option: define INSTR_FETCH_LOOP_EN to wrap to word 0 at the end of the
// program instead of entering DONE.
module instr_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic [3:0]  load_addr,
    input  logic [15:0] load_data,
    input  logic [4:0]  prog_len,
    input  logic        start,
    input  logic        stall,
    input  logic        abort,
    output logic [15:0] instruction,
    output logic        instr_valid,
    output logic [3:0]  pc,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [3:0]  pc_q, pc_d, last_q, last_d, nxt_pc;
    logic [15:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [15:0] mem_q [16];
    logic        load_ok, start_ok;
    assign load_ok  = load_en && state_q != RUN;
    assign start_ok = start && !load_en && prog_len != 5'd0 && state_q != RUN;
    assign nxt_pc   = pc_q + 4'd1;
    // Program memory has no reset so a loaded program survives rst_n.
    always_ff @(posedge clk) begin
        if (load_ok) mem_q[load_addr] <= load_data;
    end
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        last_d  = last_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (load_ok) begin
                    state_d = IDLE;
                end else if (start_ok) begin
                    state_d = RUN;
                    pc_d    = 4'd0;
                    instr_d = mem_q[0];
                    valid_d = 1'b1;
                    // Index of the final word; lengths of 16 and above all end at 15.
                    last_d  = prog_len[4] ? 4'hF : prog_len[3:0] - 4'd1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    pc_d    = 4'd0;
                end else if (stall) begin
                    valid_d = 1'b0;
                end else if (!valid_q) begin
                    // Word held by a stall has not been consumed yet: offer it again.
                    valid_d = 1'b1;
                end else if (pc_q == last_q) begin
`ifdef INSTR_FETCH_LOOP_EN
                    pc_d    = 4'd0;
                    instr_d = mem_q[0];
                    valid_d = 1'b1;
`else
                    state_d = DONE;
`endif
                end else begin
                    pc_d    = nxt_pc;
                    instr_d = mem_q[nxt_pc];
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= 4'd0;
            instr_q <= 16'h0000;
            valid_q <= 1'b0;
            last_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = state_q == RUN;
    assign done        = state_q == DONE;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized and directed checks of instr_fetch against an issue-order model.
module tb_instr_fetch;
    logic        clk = 1'b0, rst_n = 1'b0, load_en = 1'b0, start = 1'b0, stall = 1'b0, abort = 1'b0;
    logic [3:0]  load_addr = 4'd0;
    logic [15:0] load_data = 16'd0;
    logic [4:0]  prog_len = 5'd0;
    logic [15:0] instruction;
    logic        instr_valid, busy, done;
    logic [3:0]  pc;
    int          n_chk = 0, n_pass = 0;
    logic [15:0] mdl_mem [16];
    bit          mdl_done = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .prog_len(prog_len), .start(start), .stall(stall),
        .abort(abort), .instruction(instruction), .instr_valid(instr_valid),
        .pc(pc), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_instr"}, 32'(instruction), 0);
        check({tag, "_valid"}, 32'(instr_valid), 0);
        check({tag, "_pc"}, 32'(pc), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d, input bit with_start);
        load_en = 1'b1; load_addr = a; load_data = d; start = with_start; prog_len = 5'd3;
        @(posedge clk); #1;
        load_en = 1'b0; start = 1'b0;
        mdl_mem[a] = d;
        mdl_done = 0;
        check("load_busy", 32'(busy), 0);
        check("load_done", 32'(done), 0);
    endtask

    // mode 0: free run, 1: random stall/abort/junk loads, 2: stall twice at word 1,
    // 3: junk load at word 0 then abort at word 1
    task automatic run(input logic [4:0] len, input int mode, input int stall_pct, input int abort_pct);
        int n, idx, cyc, vs, issued, held;
        bit fin, prev_stall, ab, st, iss;
        n = len > 5'd16 ? 16 : int'(len);
        prog_len = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) begin
            check("len0_busy", 32'(busy), 0);
            check("len0_valid", 32'(instr_valid), 0);
            check("len0_done", 32'(done), 32'(mdl_done));
            return;
        end
        idx = 0; cyc = 0; vs = 0; issued = 0; held = 0; fin = 0; prev_stall = 0;
        while (!fin && cyc < 300) begin
            check("run_busy", 32'(busy), 1);
            check("run_done", 32'(done), 0);
            check("run_pc", 32'(pc), idx);
            check("run_instr", 32'(instruction), 32'(mdl_mem[idx]));
            check("run_valid", 32'(instr_valid), prev_stall ? 0 : 1);
            st = mode == 2 ? (idx == 1 && held < 2) : ($urandom_range(99) < stall_pct);
            ab = (mode == 3 && idx == 1) || ($urandom_range(99) < abort_pct);
`ifdef INSTR_FETCH_LOOP_EN
            ab = ab || issued >= 3 * n;
`endif
            held += st ? 1 : 0;
            vs += (instr_valid || st) ? 1 : 0;
            iss = instr_valid && !st && !ab;
            stall = st; abort = ab;
            if ((mode == 1 && $urandom_range(3) == 0) || (mode == 3 && idx == 0)) begin
                load_en = 1'b1;
                load_addr = mode == 3 ? 4'd0 : 4'($urandom);
                load_data = mode == 3 ? ~mdl_mem[0] : 16'($urandom);
            end
            @(posedge clk); #1;
            stall = 1'b0; abort = 1'b0; load_en = 1'b0;
            cyc++;
            if (ab) begin
                fin = 1; mdl_done = 0;
                check("abort_valid", 32'(instr_valid), 0);
                check("abort_pc", 32'(pc), 0);
                check("abort_busy", 32'(busy), 0);
                check("abort_done", 32'(done), 0);
            end else if (iss) begin
                issued++; idx++;
                if (idx == n) begin
`ifdef INSTR_FETCH_LOOP_EN
                    idx = 0;
`else
                    fin = 1; mdl_done = 1;
                    check("end_done", 32'(done), 1);
                    check("end_busy", 32'(busy), 0);
                    check("end_valid", 32'(instr_valid), 0);
                    check("end_pc", 32'(pc), n - 1);
                    check("end_instr", 32'(instruction), 32'(mdl_mem[n - 1]));
`endif
                end
            end
            prev_stall = st;
        end
        check("run_finished", 32'(fin), 1);
`ifndef INSTR_FETCH_LOOP_EN
        if (mode == 2) check("stall_cycles", vs, 5);
`endif
    endtask

    initial begin
        #2;
        check_reset("reset");
        #21 rst_n = 1'b1;
        load(4'd0, 16'h0051, 0);
        load(4'd1, 16'h0062, 0);
        load(4'd2, 16'hB012, 0);
        run(5'd3, 0, 0, 0);
        run(5'd3, 2, 0, 0);
        load(4'd3, 16'h0C3A, 0);
        run(5'd0, 0, 0, 0);
        for (int i = 0; i < 16; i++) load(4'(i), 16'($urandom), 0);
        run(5'd20, 0, 0, 0);
        run(5'd3, 3, 0, 0);
        run(5'd1, 0, 0, 0);
        load(4'd5, 16'h1234, 1);
        run(5'd6, 0, 0, 0);
        prog_len = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1 check_reset("midrun_reset");
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset("after_reset");
        mdl_done = 0;
        run(5'd3, 0, 0, 0);
        for (int i = 0; i < 25; i++) begin
            load(4'($urandom), 16'($urandom), 0);
            run(5'($urandom_range(31)), 1, 25, 3);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
